// File: rtl/ring_token_channel_if.sv
// Handshake bundle between the ring channel and its driver/monitor.
// The driver (master) owns send_en/loss; the channel (slave) owns the events.
interface ring_token_channel_if #(
    parameter int HW = 2
);
    logic          send_en;
    logic          loss;
    logic [HW-1:0] token_pos;
    logic          advance;
    logic          loss_evt;
    logic          ring_reset;
    logic          lap_done;
    logic [3:0]    retry_cnt;
    logic          busy;

    modport master (
        output send_en, loss,
        input  token_pos, advance, loss_evt,
        input  ring_reset, lap_done, retry_cnt, busy
    );

    modport slave (
        input  send_en, loss,
        output token_pos, advance, loss_evt,
        output ring_reset, lap_done, retry_cnt, busy
    );
endinterface

// File: rtl/ring_token_channel.sv
// Lossy token-passing ring: one-cycle hops, bounded retransmit with
// backoff, and token regeneration at node 0 once retries run out.
module ring_token_channel #(
    parameter int N           = 4,
    parameter int HW          = 2,
    parameter int BACKOFF     = 3,
    parameter int MAX_RETRY   = 3,
    parameter int RECOVER_CYC = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ring_token_channel_if.slave    ch
);
    typedef enum logic [1:0] {
        S_HOLD,
        S_FLIGHT,
        S_BACKOFF,
        S_RECOVER
    } state_t;

    state_t        state_q;
    logic [HW-1:0] pos_q;
    logic [HW-1:0] dest_d;
    logic [3:0]    retry_q;
    logic [3:0]    retry_d;
    logic [3:0]    cnt_q;
    logic          adv_q;
    logic          loss_q;
    logic          rr_q;
    logic          lap_q;

    // Sender keeps the token while in flight, so dest follows pos_q.
    assign dest_d  = (pos_q == HW'(N - 1)) ? '0 : pos_q + HW'(1);
    assign retry_d = retry_q + 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_HOLD;
            pos_q   <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            adv_q   <= 1'b0;
            loss_q  <= 1'b0;
            rr_q    <= 1'b0;
            lap_q   <= 1'b0;
        end else begin
            adv_q  <= 1'b0;
            loss_q <= 1'b0;
            rr_q   <= 1'b0;
            lap_q  <= 1'b0;
            unique case (state_q)
                S_HOLD: begin
                    if (ch.send_en) state_q <= S_FLIGHT;
                end
                S_FLIGHT: begin
                    if (!ch.loss) begin
                        pos_q   <= dest_d;
                        adv_q   <= 1'b1;
                        lap_q   <= (dest_d == '0);
                        retry_q <= '0;
                        state_q <= S_HOLD;
                    end else if (retry_d < 4'(MAX_RETRY)) begin
                        loss_q  <= 1'b1;
                        retry_q <= retry_d;
                        cnt_q   <= 4'(BACKOFF);
                        state_q <= S_BACKOFF;
                    end else begin
                        loss_q  <= 1'b1;
                        rr_q    <= 1'b1;
                        retry_q <= '0;
                        cnt_q   <= 4'(RECOVER_CYC);
                        state_q <= S_RECOVER;
                    end
                end
                S_BACKOFF: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= S_FLIGHT;
                end
                S_RECOVER: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pos_q   <= '0;
                        state_q <= S_HOLD;
                    end
                end
                default: state_q <= S_HOLD;
            endcase
        end
    end

    assign ch.token_pos  = pos_q;
    assign ch.advance    = adv_q;
    assign ch.loss_evt   = loss_q;
    assign ch.ring_reset = rr_q;
    assign ch.lap_done   = lap_q;
    assign ch.retry_cnt  = retry_q;
    assign ch.busy       = (state_q != S_HOLD);
endmodule

// File: tb/tb_ring_token_channel.sv
// Directed vector bench for ring_token_channel: default ring plus a
// MAX_RETRY=1 instance for the immediate-regeneration corner.
module tb_ring_token_channel;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ring_token_channel_if #(.HW(2)) m1 ();
    ring_token_channel_if #(.HW(2)) m2 ();

    ring_token_channel #(
        .N(4), .HW(2), .BACKOFF(3), .MAX_RETRY(3), .RECOVER_CYC(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ch(m1)
    );

    ring_token_channel #(
        .N(4), .HW(2), .BACKOFF(3), .MAX_RETRY(1), .RECOVER_CYC(2)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .ch(m2)
    );

    typedef struct {
        logic       se;
        logic       l;
        logic [1:0] pos;
        logic       adv;
        logic       le;
        logic       rr;
        logic       lap;
        logic [3:0] rc;
        logic       bz;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(
        logic se, logic l, logic [1:0] pos, logic adv, logic le,
        logic rr, logic lap, logic [3:0] rc, logic bz);
        vec_t t;
        t.se = se; t.l = l; t.pos = pos; t.adv = adv; t.le = le;
        t.rr = rr; t.lap = lap; t.rc = rc; t.bz = bz;
        return t;
    endfunction

    function automatic logic [10:0] pk(
        logic [1:0] pos, logic adv, logic le, logic rr,
        logic lap, logic [3:0] rc, logic bz);
        return {pos, adv, le, rr, lap, rc, bz};
    endfunction

    function automatic logic [10:0] act1();
        return pk(m1.token_pos, m1.advance, m1.loss_evt,
                  m1.ring_reset, m1.lap_done, m1.retry_cnt, m1.busy);
    endfunction

    function automatic logic [10:0] act2();
        return pk(m2.token_pos, m2.advance, m2.loss_evt,
                  m2.ring_reset, m2.lap_done, m2.retry_cnt, m2.busy);
    endfunction

    task automatic chk(string name, logic [10:0] a, logic [10:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got pos/adv/le/rr/lap/rc/busy=%b want %b",
                     name, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m1.send_en = 1'b0; m1.loss = 1'b0;
        m2.send_en = 1'b0; m2.loss = 1'b0;

        // full lap
        vq.push_back(v(1,0,0,0,0,0,0,0,1));
        vq.push_back(v(1,0,1,1,0,0,0,0,0));
        vq.push_back(v(1,0,1,0,0,0,0,0,1));
        vq.push_back(v(1,0,2,1,0,0,0,0,0));
        vq.push_back(v(1,0,2,0,0,0,0,0,1));
        vq.push_back(v(1,0,3,1,0,0,0,0,0));
        vq.push_back(v(1,0,3,0,0,0,0,0,1));
        vq.push_back(v(1,0,0,1,0,0,1,0,0));
        // to node 1, single loss, backoff with loss ignored
        vq.push_back(v(1,0,0,0,0,0,0,0,1));
        vq.push_back(v(1,0,1,1,0,0,0,0,0));
        vq.push_back(v(1,0,1,0,0,0,0,0,1));
        vq.push_back(v(0,1,1,0,1,0,0,1,1));
        vq.push_back(v(0,1,1,0,0,0,0,1,1));
        vq.push_back(v(0,1,1,0,0,0,0,1,1));
        vq.push_back(v(0,0,1,0,0,0,0,1,1));
        vq.push_back(v(0,0,2,1,0,0,0,0,0));
        // three losses at node 2 -> ring reset
        vq.push_back(v(1,0,2,0,0,0,0,0,1));
        vq.push_back(v(0,1,2,0,1,0,0,1,1));
        vq.push_back(v(0,0,2,0,0,0,0,1,1));
        vq.push_back(v(0,0,2,0,0,0,0,1,1));
        vq.push_back(v(0,0,2,0,0,0,0,1,1));
        vq.push_back(v(0,1,2,0,1,0,0,2,1));
        vq.push_back(v(0,0,2,0,0,0,0,2,1));
        vq.push_back(v(0,0,2,0,0,0,0,2,1));
        vq.push_back(v(0,0,2,0,0,0,0,2,1));
        vq.push_back(v(0,1,2,0,1,1,0,0,1));
        vq.push_back(v(0,1,2,0,0,0,0,0,1));
        vq.push_back(v(0,1,0,0,0,0,0,0,0));
        // loss in HOLD is ignored
        vq.push_back(v(0,1,0,0,0,0,0,0,0));
        vq.push_back(v(0,1,0,0,0,0,0,0,0));
        // walk to node 3, two losses
        vq.push_back(v(1,0,0,0,0,0,0,0,1));
        vq.push_back(v(1,0,1,1,0,0,0,0,0));
        vq.push_back(v(1,0,1,0,0,0,0,0,1));
        vq.push_back(v(1,0,2,1,0,0,0,0,0));
        vq.push_back(v(1,0,2,0,0,0,0,0,1));
        vq.push_back(v(1,0,3,1,0,0,0,0,0));
        vq.push_back(v(1,0,3,0,0,0,0,0,1));
        vq.push_back(v(0,1,3,0,1,0,0,1,1));
        vq.push_back(v(0,0,3,0,0,0,0,1,1));
        vq.push_back(v(0,0,3,0,0,0,0,1,1));
        vq.push_back(v(0,0,3,0,0,0,0,1,1));
        vq.push_back(v(0,1,3,0,1,0,0,2,1));

        tick();
        chk("reset", act1(), pk(0,0,0,0,0,0,0));
        tick();
        reset_n = 1'b1;

        foreach (vq[i]) begin
            m1.send_en = vq[i].se;
            m1.loss    = vq[i].l;
            tick();
            chk($sformatf("vec%0d", i + 1), act1(),
                pk(vq[i].pos, vq[i].adv, vq[i].le, vq[i].rr,
                   vq[i].lap, vq[i].rc, vq[i].bz));
        end

        // async reset mid-BACKOFF while loss_evt is high
        m1.send_en = 1'b0;
        m1.loss    = 1'b0;
        #1 reset_n = 1'b0;
        #1 chk("async_rst", act1(), pk(0,0,0,0,0,0,0));
        tick();
        reset_n = 1'b1;
        m1.send_en = 1'b1;
        tick();
        chk("resume_fl", act1(), pk(0,0,0,0,0,0,1));
        tick();
        chk("resume_adv", act1(), pk(1,1,0,0,0,0,0));
        m1.send_en = 1'b0;

        // MAX_RETRY=1 instance: walk to node 3
        for (int h = 0; h < 3; h++) begin
            m2.send_en = 1'b1;
            tick();
            chk($sformatf("mr1_fl%0d", h), act2(),
                pk(2'(h),0,0,0,0,0,1));
            tick();
            chk($sformatf("mr1_hop%0d", h), act2(),
                pk(2'(h + 1),1,0,0,0,0,0));
        end
        tick();
        chk("mr1_fl3", act2(), pk(3,0,0,0,0,0,1));
        m2.send_en = 1'b0;
        m2.loss    = 1'b1;
        tick();
        chk("mr1_loss", act2(), pk(3,0,1,1,0,0,1));
        m2.loss = 1'b0;
        tick();
        chk("mr1_rec", act2(), pk(3,0,0,0,0,0,1));
        tick();
        chk("mr1_regen", act2(), pk(0,0,0,0,0,0,0));
        tick();
        chk("mr1_idle", act2(), pk(0,0,0,0,0,0,0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
